load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/load_aligner.sv | 29 ++
 rtl/load_store_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: request op encodings, FSM states,
// and the legality and alignment checks used when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_READ,
    S_STORE,
    S_RESP
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      OP_H, OP_HU: return lo[0];
      OP_W:        return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Unsigned codes only make sense for loads; a store carrying one is rejected.
  function automatic logic is_illegal(input logic [2:0] op, input logic write);
    case (op)
      OP_B, OP_H, OP_W: return 1'b0;
      OP_BU, OP_HU:     return write;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational load-data lane select with sign or zero extension.
module load_aligner
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_op,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Half lane comes from bit 1 only, so a half access with bit 0 set is force-aligned.
  assign w_byte = i_word[{i_lane, 3'b000} +: 8];
  assign w_half = i_word[{i_lane[1], 4'b0000} +: 16];

  always_comb begin
    o_data = i_word;
    case (i_op)
      OP_B:    o_data = {{24{w_byte[7]}}, w_byte};
      OP_BU:   o_data = {24'd0, w_byte};
      OP_H:    o_data = {{16{w_half[15]}}, w_half};
      OP_HU:   o_data = {16'd0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit with read-modify-write for sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of force-aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [2:0]  reqOp,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respData,
  output logic        respError,
  output logic [31:0] memAddress,
  output logic        memWriteEnabled,
  output logic [31:0] memWriteInput,
  input  logic [31:0] memReadResult
);

  lsu_state_t              r_state, w_next;
  logic [2:0]              r_op;
  logic [ADDR_WIDTH+1:0]   r_addr;
  logic [15:0]             r_wdata;
  logic [31:0]             r_word;
  logic [31:0]             r_respData;
  logic                    r_respError;
  logic                    w_accept;
  logic                    w_bad;
  logic [31:0]             w_loadData;
  logic [31:0]             w_merged;

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [15:0] data,
                                              input logic [2:0] op, input logic [1:0] lo);
    logic [31:0] m;
    m = word;
    if (op == OP_B) m[{lo, 3'b000} +: 8] = data[7:0];
    else            m[{lo[1], 4'b0000} +: 16] = data;
    return m;
  endfunction

  assign w_accept = reqValid && reqReady;
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_bad = is_illegal(reqOp, reqWrite) || is_misaligned(reqOp, reqAddress[1:0]);
`else
  assign w_bad = is_illegal(reqOp, reqWrite);
`endif

  load_aligner u_load_aligner (
    .i_word (memReadResult),
    .i_lane (r_addr[1:0]),
    .i_op   (r_op),
    .o_data (w_loadData)
  );

  assign w_merged = merge_store(memReadResult, r_wdata, r_op, r_addr[1:0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_bad)              w_next = S_RESP;
          else if (!reqWrite)     w_next = S_LOAD;
          else if (reqOp == OP_W) w_next = S_STORE;
          else                    w_next = S_RMW_READ;
        end
      end
      S_LOAD:     w_next = S_RESP;
      S_RMW_READ: w_next = S_STORE;
      S_STORE:    w_next = S_RESP;
      S_RESP:     if (respReady) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    reqReady        = (r_state == S_IDLE) && !reset;
    respValid       = (r_state == S_RESP);
    memWriteEnabled = (r_state == S_STORE);
  end

  // Request latch and response capture; r_word holds the word that STORE writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op        <= OP_B;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_word      <= '0;
      r_respData  <= '0;
      r_respError <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op        <= reqOp;
          r_addr      <= reqAddress[ADDR_WIDTH+1:0];
          r_wdata     <= reqWriteData[15:0];
          r_word      <= reqWriteData;
          r_respData  <= '0;
          r_respError <= w_bad;
        end
        S_LOAD:     r_respData <= w_loadData;
        S_RMW_READ: r_word     <= w_merged;
        default:    ;
      endcase
    end
  end

  assign memAddress    = {{(32 - ADDR_WIDTH){1'b0}}, r_addr[ADDR_WIDTH+1:2]};
  assign memWriteInput = r_word;
  assign respData      = r_respData;
  assign respError     = r_respError;

endmodule
